// File: rtl/joypad_port_ctrl.sv
// joypad_port_ctrl: NES controller-port emulator serving $4016/$4017 from one shared latch.
// Optional A/B turbo is built in when the JOYPAD_TURBO_EN macro is defined.
module joypad_port_ctrl #(
  parameter int unsigned FOUR_SCORE  = 0,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TURBO_DIV   = 1500000
) (
  input  logic                                   clk_in,
  input  logic                                   rst_n_in,
  input  logic                                   joypad_latch,
  input  logic [1:0]                             joypad_clk,
  input  logic [(FOUR_SCORE != 0 ? 32 : 16)-1:0] btn_in,
`ifdef JOYPAD_TURBO_EN
  input  logic [(FOUR_SCORE != 0 ? 8 : 4)-1:0]   turbo_in,
`endif
  output logic [1:0]                             joypad_data
);

  localparam int unsigned NPADS = (FOUR_SCORE != 0) ? 4 : 2;
  localparam int unsigned LEN   = (FOUR_SCORE != 0) ? 24 : 8;
  localparam int unsigned CW    = 5;

  logic [SYNC_STAGES-1:0]      latch_sync_q;
  logic [1:0][SYNC_STAGES-1:0] clk_sync_q;
  logic [1:0]                  clk_dly_q;
  logic                        latch_s_c;
  logic [1:0]                  clk_s_c;
  logic [1:0]                  rise_c;
  logic [NPADS-1:0][7:0]       pads_c;

  // Input synchronisers plus a one-cycle delayed copy of the synced clocks for edge detect
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      latch_sync_q <= '0;
      clk_sync_q   <= '0;
      clk_dly_q    <= '0;
    end else begin
      latch_sync_q[0]  <= joypad_latch;
      clk_sync_q[0][0] <= joypad_clk[0];
      clk_sync_q[1][0] <= joypad_clk[1];
      for (int i = 1; i < SYNC_STAGES; i++) begin
        latch_sync_q[i]  <= latch_sync_q[i-1];
        clk_sync_q[0][i] <= clk_sync_q[0][i-1];
        clk_sync_q[1][i] <= clk_sync_q[1][i-1];
      end
      clk_dly_q <= clk_s_c;
    end
  end

  assign latch_s_c  = latch_sync_q[SYNC_STAGES-1];
  assign clk_s_c[0] = clk_sync_q[0][SYNC_STAGES-1];
  assign clk_s_c[1] = clk_sync_q[1][SYNC_STAGES-1];
  assign rise_c     = clk_s_c & ~clk_dly_q;

`ifdef JOYPAD_TURBO_EN
  localparam int unsigned TW = (TURBO_DIV > 1) ? $clog2(TURBO_DIV) : 1;

  logic [TW-1:0] tcnt_d, tcnt_q;
  logic          phase_d, phase_q;

  // Free-running turbo divider; phase flips on every wrap
  always_comb begin
    tcnt_d  = tcnt_q + TW'(1);
    phase_d = phase_q;
    if (tcnt_q == TW'(TURBO_DIV - 1)) begin
      tcnt_d  = '0;
      phase_d = ~phase_q;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tcnt_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      tcnt_q  <= tcnt_d;
      phase_q <= phase_d;
    end
  end

  // Turbo masks A/B during the off phase; turbo alone never reads as pressed
  always_comb begin
    pads_c = btn_in;
    for (int k = 0; k < NPADS; k++) begin
      pads_c[k][0] = btn_in[8*k]   & (~turbo_in[2*k]   | phase_q);
      pads_c[k][1] = btn_in[8*k+1] & (~turbo_in[2*k+1] | phase_q);
    end
  end
`else
  assign pads_c = btn_in;
`endif

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [LEN-1:0] image_c;
    logic [LEN-1:0] sr_d, sr_q;
    logic [CW-1:0]  cnt_d, cnt_q;

    if (FOUR_SCORE != 0) begin : g_fs
      localparam logic [7:0] SIG = (p == 0) ? 8'h10 : 8'h20;
      assign image_c = {SIG, pads_c[p+2], pads_c[p]};
    end else begin : g_std
      assign image_c = pads_c[p];
    end

    // Latch has priority over a coincident clock edge; exhausted reads shift in 1s
    always_comb begin
      sr_d  = sr_q;
      cnt_d = cnt_q;
      if (latch_s_c) begin
        sr_d  = image_c;
        cnt_d = '0;
      end else if (rise_c[p]) begin
        sr_d = {1'b1, sr_q[LEN-1:1]};
        if (cnt_q != CW'(LEN)) begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
        sr_q  <= '1;
        cnt_q <= CW'(LEN);
      end else begin
        sr_q  <= sr_d;
        cnt_q <= cnt_d;
      end
    end

    assign joypad_data[p] = sr_q[0];
  end

endmodule
